// File: rtl/broomstick_rom.sv
// -----------------------------------------------------------------------------
// broomstick_rom
//
// Read-only 1-bit sprite memory for a 100x100 broom bitmap stored row-major.
// The sprite renderer inverts q, so a stored 0 is a drawn broom pixel and a
// stored 1 is background. The bitmap is not held in an array. It is generated
// from three geometric regions along the main diagonal:
//   handle   : rows/cols 4..61,  |c - r| <= 1
//   binding  : rows/cols 62..67, |c - r| <= 3
//   bristles : rows/cols 68..97, |c - r| <= floor((r + c - 136) / 4)
// Addresses at or above 10000 read as background.
//
// Ports
//   clock    in   1   sole clock (the renderer's inverted pixel clock)
//   reset    in   1   synchronous, active-high; forces q to background
//   address  in  14   pixel index, row*100 + col
//   q        out  1   registered pixel value, one-cycle latency
//                     (0 = broom, 1 = background)
// -----------------------------------------------------------------------------
module broomstick_rom (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] address,
  output logic        q
);

  localparam logic [13:0] NUM_PIXELS = 14'd10000;
  localparam logic [13:0] NUM_COLS   = 14'd100;

  // Address decode. All arithmetic stays at 14 bits: an out-of-range address
  // yields a row of 100..163, which no region box contains, so the decode
  // needs no special narrowing.
  logic [13:0] row_w;
  logic [13:0] col_w;
  logic [13:0] diff_w;
  logic [13:0] fan_w;

  assign row_w  = address / NUM_COLS;
  assign col_w  = address - (row_w * NUM_COLS);
  assign diff_w = (col_w >= row_w) ? (col_w - row_w) : (row_w - col_w);
  // Only consulted inside the bristle box, where r + c >= 136, so the
  // subtraction never wraps there and the shift is an exact floor.
  assign fan_w  = (row_w + col_w - 14'd136) >> 2;

  logic in_range_w;
  logic hit_handle_w;
  logic hit_binding_w;
  logic hit_bristle_w;
  logic q_d;

  assign in_range_w = (address < NUM_PIXELS);

  assign hit_handle_w  = (row_w >= 14'd4)  && (row_w <= 14'd61) &&
                         (col_w >= 14'd4)  && (col_w <= 14'd61) &&
                         (diff_w <= 14'd1);

  assign hit_binding_w = (row_w >= 14'd62) && (row_w <= 14'd67) &&
                         (col_w >= 14'd62) && (col_w <= 14'd67) &&
                         (diff_w <= 14'd3);

  assign hit_bristle_w = (row_w >= 14'd68) && (row_w <= 14'd97) &&
                         (col_w >= 14'd68) && (col_w <= 14'd97) &&
                         (diff_w <= fan_w);

  // Stored value is inverted: a broom pixel reads as 0.
  assign q_d = ~(in_range_w && (hit_handle_w || hit_binding_w || hit_bristle_w));

  // Power-up value is background, before any clock edge.
  logic q_q = 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge; only the output register is
  // reset, since the bitmap itself is constant logic with nothing to clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= 1'b1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_broomstick_rom.sv
// -----------------------------------------------------------------------------
// tb_broomstick_rom
//
// Self-checking bench for broomstick_rom. A bitmap is painted in the bench by
// sweeping each region row by row. A scoreboard process predicts q on every
// edge from that bitmap and the reset input. It compares on the following
// falling edge. Directed reads also compare against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_broomstick_rom;

  logic        clock;
  logic        reset;
  logic [13:0] address;
  logic        q;

  broomstick_rom dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .q       (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference bitmap: 1 marks a broom pixel.
  // ---------------------------------------------------------------------------
  bit broom_map [10000];
  int model_broom_count;

  task automatic paint_model();
    for (int i = 0; i < 10000; i++) broom_map[i] = 1'b0;
    // handle: a 3-wide stripe along the diagonal, clipped to its box
    for (int r = 4; r <= 61; r++)
      for (int c = r - 1; c <= r + 1; c++)
        if (c >= 4 && c <= 61) broom_map[r * 100 + c] = 1'b1;
    // binding: a 7-wide stripe, clipped to its box
    for (int r = 62; r <= 67; r++)
      for (int c = r - 3; c <= r + 3; c++)
        if (c >= 62 && c <= 67) broom_map[r * 100 + c] = 1'b1;
    // bristles: the spread widens with distance along the diagonal
    for (int r = 68; r <= 97; r++)
      for (int c = 68; c <= 97; c++) begin
        int d;
        d = (c > r) ? (c - r) : (r - c);
        if (d <= (r + c - 136) / 4) broom_map[r * 100 + c] = 1'b1;
      end
    model_broom_count = 0;
    for (int i = 0; i < 10000; i++) if (broom_map[i]) model_broom_count++;
  endtask

  function automatic logic model_q(input int a);
    if (a >= 10000) return 1'b1;
    return broom_map[a] ? 1'b0 : 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: predict at each rising edge and compare at the next falling edge.
  // ---------------------------------------------------------------------------
  logic exp_q     = 1'b1;
  bit   exp_valid = 1'b0;

  always @(posedge clock) begin
    exp_q     <= reset ? 1'b1 : model_q(int'(address));
    exp_valid <= 1'b1;
  end

  always @(negedge clock) begin
    if (exp_valid) check("stream", q, exp_q);
  end

  // Drive an address at the falling edge. Let one rising edge sample it, then
  // compare q to a literal at the next falling edge.
  task automatic read_lit(input int a, input logic expected, input string name);
    address = 14'(a);
    @(posedge clock);
    @(negedge clock);
    check(name, q, expected);
  endtask

  int dut_broom_count;

  initial begin
    paint_model();
    reset   = 1'b0;
    address = 14'd0;

    // Power-up value before any edge
    #1;
    check("powerup", q, 1'b1);

    // Pin the painted model against hand-derived pixels
    check("model_505",  model_q(505),  1'b0);
    check("model_508",  model_q(508),  1'b1);
    check("model_6365", model_q(6365), 1'b0);
    check("model_9790", model_q(9790), 1'b0);
    check("model_6869", model_q(6869), 1'b1);

    // Reset held for two edges with a broom address applied
    @(negedge clock);
    reset   = 1'b1;
    address = 14'd505;
    @(posedge clock); @(negedge clock);
    check("reset_edge1", q, 1'b1);
    @(posedge clock); @(negedge clock);
    check("reset_edge2", q, 1'b1);
    reset = 1'b0;
    read_lit(505, 1'b0, "first_after_reset");

    // Handle and edges
    read_lit(0,    1'b1, "a0");
    read_lit(505,  1'b0, "a505");
    read_lit(506,  1'b0, "a506");
    read_lit(508,  1'b1, "a508");
    read_lit(6161, 1'b0, "a6161");
    read_lit(403,  1'b1, "a403");

    // Binding and bristles
    read_lit(6365, 1'b0, "a6365");
    read_lit(6367, 1'b1, "a6367");
    read_lit(8080, 1'b0, "a8080");
    read_lit(9790, 1'b0, "a9790");
    read_lit(9760, 1'b1, "a9760");
    read_lit(6868, 1'b0, "a6868");
    read_lit(6869, 1'b1, "a6869");

    // Bounds, then an in-range read right after to expose stale state
    read_lit(9999,  1'b1, "a9999");
    read_lit(10000, 1'b1, "a10000");
    read_lit(16383, 1'b1, "a16383");
    read_lit(505,   1'b0, "a505_after_oob");

    // Full sweep. The scoreboard checks each pixel; here DUT broom pixels are tallied.
    dut_broom_count = 0;
    for (int a = 0; a < 10000; a++) begin
      address = 14'(a);
      @(posedge clock);
      @(negedge clock);
      if (q === 1'b0) dut_broom_count++;
    end
    total++;
    if (dut_broom_count != model_broom_count) begin
      bad++;
      $display("FAIL broom_count: got %0d expected %0d", dut_broom_count, model_broom_count);
    end

    // Mid-stream reset: assert reset on the edge that samples 506
    read_lit(505, 1'b0, "mid_505");
    reset = 1'b1;
    read_lit(506, 1'b1, "mid_reset_506");
    reset = 1'b0;
    read_lit(507, 1'b1, "mid_after_507");
    read_lit(505, 1'b0, "mid_resume_505");

    // Random addresses over the full 14-bit space with sporadic resets
    for (int i = 0; i < 2000; i++) begin
      address = 14'($urandom_range(0, 16383));
      reset   = ($urandom_range(0, 15) == 0);
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
